// File: rtl/cpu_pkg.sv
// Shared CPU constants, the queued command format and sequencer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned REG_W  = 2;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OP_W-1:0] OP_STORE = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OP_W-1:0] OP_MUL   = 3'b011;
  localparam logic [OP_W-1:0] OP_INIT  = 3'b100;

  // One queued command; reg_sel is the register select (reg is a keyword).
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  reg_sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] init;
  } cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } seq_state_t;

  // Number of cycles a command holds the CPU inputs.
  function automatic logic [2:0] op_cycles(input logic [OP_W-1:0] op,
                                           input logic [2:0]      load_cyc,
                                           input logic [2:0]      store_cyc);
    logic [2:0] cyc;
    cyc = 3'd1;
    if (op == OP_LOAD) begin
      cyc = load_cyc;
    end else if (op == OP_STORE) begin
      cyc = store_cyc;
    end
    return cyc;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with flush; pointers carry one wrap bit.
// Latency: a push is visible at the head one cycle after the pushing edge.
// Backpressure: push ignored when full; flush drops contents and a same-edge push.
module cmd_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = $bits(cmd_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign push_ok  = push && !full && !flush;
  assign pop_ok   = pop && !empty && !flush;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush snaps the read pointer onto the pre-edge write pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/cpu_cmd_sequencer.sv
// Queues CPU commands and holds each on the CPU inputs for its cycle count (perf counters: CPU_CMD_SEQ_PERF_EN).
// Latency: pushed at edge E into an idle empty queue, driven to the CPU from edge E+1.
// Backpressure: cmd_ready = !full from registered state; a pop frees a slot only the next cycle.
module cpu_cmd_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     DEPTH        = 4,
  parameter int unsigned     LOAD_CYCLES  = 2,
  parameter int unsigned     STORE_CYCLES = 1,
  parameter logic [OP_W-1:0] IDLE_OP      = 3'b011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [REG_W-1:0]  cmd_reg,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_init,
  input  logic              flush,
  output logic [OP_W-1:0]   cpu_instruction,
  output logic [REG_W-1:0]  cpu_reg_addr,
  output logic [ADDR_W-1:0] cpu_mem_address,
  output logic [DATA_W-1:0] cpu_init_value,
  output logic              busy,
  output logic              done,
  output logic [OP_W-1:0]   done_op
`ifdef CPU_CMD_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_retired,
  output logic [15:0]       perf_stall
`endif
);

  seq_state_t        state, state_nxt;
  logic [2:0]        hold, hold_nxt;
  logic [OP_W-1:0]   instr_nxt;
  logic [REG_W-1:0]  reg_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] init_nxt;
  logic              done_nxt;
  logic [OP_W-1:0]   done_op_nxt;
  logic              take_head;
  logic              fifo_full;
  logic              fifo_empty;
  cmd_t              push_cmd;
  cmd_t              head_cmd;
  logic [2:0]        head_cycles;

  assign push_cmd    = '{op: cmd_op, reg_sel: cmd_reg, addr: cmd_addr, init: cmd_init};
  assign head_cycles = op_cycles(head_cmd.op, 3'(LOAD_CYCLES), 3'(STORE_CYCLES));
  assign cmd_ready   = !fifo_full;
  assign busy        = (state == ST_EXEC) || !fifo_empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_valid),
    .push_dat (push_cmd),
    .pop      (take_head),
    .flush    (flush),
    .head_dat (head_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Next state and next CPU drive: issue from the queue, count down the hold, or fall idle.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    instr_nxt   = cpu_instruction;
    reg_nxt     = cpu_reg_addr;
    addr_nxt    = cpu_mem_address;
    init_nxt    = cpu_init_value;
    done_nxt    = 1'b0;
    done_op_nxt = done_op;
    take_head   = 1'b0;

    case (state)
      ST_IDLE: begin
        take_head = !fifo_empty && !flush;
      end
      ST_EXEC: begin
        if (hold != 3'd0) begin
          hold_nxt = hold - 3'd1;
          if (hold == 3'd1) begin
            done_nxt    = 1'b1;
            done_op_nxt = cpu_instruction;
          end
        end else if (!fifo_empty && !flush) begin
          take_head = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          instr_nxt = IDLE_OP;
          reg_nxt   = '0;
          addr_nxt  = '0;
          init_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // A flush edge never issues: the discarded head must not reach the CPU.
    if (take_head) begin
      state_nxt = ST_EXEC;
      hold_nxt  = head_cycles - 3'd1;
      instr_nxt = head_cmd.op;
      reg_nxt   = head_cmd.reg_sel;
      addr_nxt  = head_cmd.addr;
      init_nxt  = (head_cmd.op == OP_INIT) ? head_cmd.init : '0;
      if (head_cycles == 3'd1) begin
        done_nxt    = 1'b1;
        done_op_nxt = head_cmd.op;
      end
    end
  end

  // State, hold counter and every CPU-facing output are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      hold            <= 3'd0;
      cpu_instruction <= IDLE_OP;
      cpu_reg_addr    <= '0;
      cpu_mem_address <= '0;
      cpu_init_value  <= '0;
      done            <= 1'b0;
      done_op         <= '0;
    end else begin
      state           <= state_nxt;
      hold            <= hold_nxt;
      cpu_instruction <= instr_nxt;
      cpu_reg_addr    <= reg_nxt;
      cpu_mem_address <= addr_nxt;
      cpu_init_value  <= init_nxt;
      done            <= done_nxt;
      done_op         <= done_op_nxt;
    end
  end

`ifdef CPU_CMD_SEQ_PERF_EN
  // Saturating counts of retired commands and of stalled offers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_retired <= 16'd0;
      perf_stall   <= 16'd0;
    end else begin
      if (done && (perf_retired != 16'hFFFF)) perf_retired <= perf_retired + 16'd1;
      if (cmd_valid && !cmd_ready && (perf_stall != 16'hFFFF)) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Directed bench for cpu_cmd_sequencer with a queue-based reference model.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: pushes wait on the model's room; every wait is cycle-bounded.
module tb_cpu_cmd_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LOAD_C  = 2;
  // A long store lets the queue fill up behind it.
  localparam int unsigned STORE_C = 5;
  localparam logic [2:0]  IDLE_C  = 3'b011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [1:0]   cmd_reg = '0;
  logic [8:0]   cmd_addr = '0;
  logic [511:0] cmd_init = '0;
  logic         flush = 1'b0;
  logic [2:0]   cpu_instruction;
  logic [1:0]   cpu_reg_addr;
  logic [8:0]   cpu_mem_address;
  logic [511:0] cpu_init_value;
  logic         busy;
  logic         done;
  logic [2:0]   done_op;
`ifdef CPU_CMD_SEQ_PERF_EN
  logic [15:0]  perf_retired;
  logic [15:0]  perf_stall;
`endif

  cpu_cmd_sequencer #(
    .DEPTH        (DEPTH),
    .LOAD_CYCLES  (LOAD_C),
    .STORE_CYCLES (STORE_C),
    .IDLE_OP      (IDLE_C)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_reg         (cmd_reg),
    .cmd_addr        (cmd_addr),
    .cmd_init        (cmd_init),
    .flush           (flush),
    .cpu_instruction (cpu_instruction),
    .cpu_reg_addr    (cpu_reg_addr),
    .cpu_mem_address (cpu_mem_address),
    .cpu_init_value  (cpu_init_value),
    .busy            (busy),
    .done            (done),
    .done_op         (done_op)
`ifdef CPU_CMD_SEQ_PERF_EN
    ,
    .perf_retired    (perf_retired),
    .perf_stall      (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: expected event never arrived within its cycle budget", nm);
  endtask

  // ---------------- reference model ----------------
  // Queue of accepted commands, plus the command on the CPU and its remaining cycles.
  typedef struct {
    logic [2:0]   op;
    logic [1:0]   rs;
    logic [8:0]   addr;
    logic [511:0] init;
  } m_cmd_t;

  m_cmd_t m_q[$];
  m_cmd_t m_cur;
  bit     m_act = 0;
  int     m_rem = 0;
  bit     m_acc = 0;
  bit     m_room;
  bit     started = 0;
  int     cyc = 0;

  function automatic int m_cycles(input logic [2:0] op);
    if (op == 3'b000) return LOAD_C;
    if (op == 3'b001) return STORE_C;
    return 1;
  endfunction

  always @(posedge clk) begin
    m_acc = 0;
    if (!rst_n) begin
      m_q.delete();
      m_act = 0;
      m_rem = 0;
    end else begin
      m_room = (m_q.size() < DEPTH);
      if (m_act && m_rem > 1) begin
        m_rem--;
      end else if (m_q.size() > 0 && !flush) begin
        m_cur = m_q.pop_front();
        m_act = 1;
        m_rem = m_cycles(m_cur.op);
      end else begin
        m_act = 0;
      end
      if (flush) begin
        m_q.delete();
      end else if (cmd_valid && m_room) begin
        m_q.push_back('{op: cmd_op, rs: cmd_reg, addr: cmd_addr, init: cmd_init});
        m_acc = 1;
      end
    end
    started = 1;
    cyc++;
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("cmd_ready", cmd_ready, (m_q.size() < DEPTH));
      chk("busy", busy, (m_act || m_q.size() > 0));
      chk("done", done, (m_act && m_rem == 1));
      chk("cpu_instruction", cpu_instruction, m_act ? m_cur.op : IDLE_C);
      chk("cpu_reg_addr", cpu_reg_addr, m_act ? m_cur.rs : 2'd0);
      chk("cpu_mem_address", cpu_mem_address, m_act ? m_cur.addr : 9'd0);
      chk("cpu_init_value", cpu_init_value, (m_act && m_cur.op == 3'b100) ? m_cur.init : 512'd0);
      if (m_act && m_rem == 1) chk("done_op", done_op, m_cur.op);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [2:0] op, input logic [1:0] rs, input logic [8:0] addr,
                      input logic [511:0] init, output int hs);
    int c;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = rs;
    cmd_addr  = addr;
    cmd_init  = init;
    hs = -1;
    for (int i = 0; i < 40; i++) begin
      c = cyc;
      @(posedge clk);
      #1;
      if (m_acc) begin
        hs = c;
        break;
      end
    end
    if (hs < 0) timeout_fail("send_handshake");
  endtask

  task automatic wait_instr(input logic [2:0] op, input string nm, output bit found);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_instruction == op) begin
        found = 1;
        break;
      end
    end
    if (!found) timeout_fail(nm);
  endtask

  int           hs;
  int           dcyc;
  int           seen;
  int           dpos;
  int           rdy_low;
  int           first_done;
  int           last_done;
  int           extra;
  bit           found;
  logic [2:0]   done_q[$];
  logic [2:0]   exp_ops [6];
  logic [511:0] ones;

  initial begin
    ones = '1;
    exp_ops = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b010, 3'b011};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_instr", cpu_instruction, 3'b011);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single add: done two cycles after the handshake cycle, then idle opcode.
    send(3'b010, 2'd1, 9'd0, 512'd0, hs);
    cmd_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        dcyc = cyc;
        chk("add_done_op", done_op, 3'b010);
        chk("add_reg", cpu_reg_addr, 2'd1);
        break;
      end
    end
    if (!found) timeout_fail("add_done");
    else chk("add_latency", dcyc - hs, 2);
    @(negedge clk);
    chk("add_idle_after", cpu_instruction, 3'b011);

    // Load: address held exactly two cycles, done only in the second.
    @(posedge clk); #1;
    send(3'b000, 2'd0, 9'h1A5, 512'd0, hs);
    cmd_valid = 1'b0;
    seen = 0;
    dpos = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_mem_address == 9'h1A5) begin
        seen++;
        if (done) dpos = seen;
      end
    end
    chk("load_hold_cycles", seen, 2);
    chk("load_done_pos", dpos, 2);

    // Six back-to-back commands behind a long store: ready drops, order kept, no bubbles.
    @(posedge clk); #1;
    done_q.delete();
    rdy_low = 0;
    first_done = -1;
    last_done = -1;
    fork
      begin
        send(3'b001, 2'd2, 9'h033, 512'd0, hs);
        send(3'b010, 2'd0, 9'h001, 512'd0, hs);
        send(3'b011, 2'd1, 9'h002, 512'd0, hs);
        send(3'b100, 2'd2, 9'h003, {16{32'hA5A5_0F0F}}, hs);
        send(3'b010, 2'd3, 9'h004, 512'd0, hs);
        send(3'b011, 2'd0, 9'h005, 512'd0, hs);
        cmd_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (!cmd_ready) rdy_low++;
          if (done) begin
            done_q.push_back(done_op);
            if (first_done < 0) first_done = cyc;
            last_done = cyc;
          end
        end
      end
    join
    chk("burst_ready_low_cycles", rdy_low, 2);
    chk("burst_done_count", done_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < done_q.size()) chk("burst_done_order", done_q[i], exp_ops[i]);
    end
    chk("burst_no_bubble", last_done - first_done, 5);

    // Init: all-ones for exactly one cycle.
    send(3'b100, 2'd0, 9'd0, ones, hs);
    cmd_valid = 1'b0;
    wait_instr(3'b100, "init_issue", found);
    if (found) begin
      chk("init_value", cpu_init_value, ones);
      @(negedge clk);
      chk("init_cleared", cpu_init_value, 512'd0);
    end

    // Flush during a load with three queued; a push on the flush edge is also dropped.
    @(posedge clk); #1;
    send(3'b001, 2'd0, 9'h010, 512'd0, hs);
    send(3'b000, 2'd1, 9'h0F0, 512'd0, hs);
    send(3'b010, 2'd0, 9'h011, 512'd0, hs);
    send(3'b011, 2'd0, 9'h012, 512'd0, hs);
    send(3'b010, 2'd0, 9'h013, 512'd0, hs);
    cmd_valid = 1'b0;
    wait_instr(3'b000, "flush_load_issue", found);
    if (found) begin
      flush     = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 3'b010;
      @(posedge clk); #1;
      flush     = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("flush_load_done", done, 1'b1);
      chk("flush_load_done_op", done_op, 3'b000);
      @(negedge clk);
      chk("flush_busy_fall", busy, 1'b0);
      chk("flush_idle_op", cpu_instruction, 3'b011);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk("flush_no_more_done", extra, 0);
    end

    // Reset in the first load cycle: the edge into its second cycle abandons it.
    @(posedge clk); #1;
    send(3'b000, 2'd3, 9'h1FF, 512'd0, hs);
    cmd_valid = 1'b0;
    wait_instr(3'b000, "rst_load_issue", found);
    if (found) begin
      chk("rst_mid_no_done_yet", done, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_done", done, 1'b0);
      chk("rst_mid_instr", cpu_instruction, 3'b011);
      chk("rst_mid_addr", cpu_mem_address, 9'd0);
      chk("rst_mid_reg", cpu_reg_addr, 2'd0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_ready", cmd_ready, 1'b1);
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("rst_after_done", done, 1'b0);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

endmodule
